shift_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered 8-bit `shifter` instance among `NREQ` requesters. It accepts one shift request at a time over a valid/ready handshake and drives the shifter's `din`/`dir`/`n` inputs from registers. After the shifter's latency it captures `dout` and returns it on a response channel tagged with the requester index. It sits between client blocks and the single shared shifter.

---
 rtl/shift_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that time-shares one registered 8-bit
// shifter among NREQ requesters. One operation is in flight at a time; the
// result is returned on a response channel tagged with the requester index.
module shift_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SH_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_din,
  input  logic [NREQ-1:0]           req_dir,
  input  logic [3*NREQ-1:0]         req_n,
  output logic [NREQ-1:0]           req_ready,
  output logic [7:0]                sh_din,
  output logic                      sh_dir,
  output logic [2:0]                sh_n,
  input  logic [7:0]                sh_dout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned DW  = 8;
  localparam int unsigned NW  = 3;
  localparam int unsigned CW  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_sh_din;
  logic            r_sh_dir;
  logic [NW-1:0]   r_sh_n;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_busy;

  logic [DW-1:0]   w_din_a [NREQ];
  logic [NW-1:0]   w_n_a   [NREQ];
  logic            w_found;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_req_ready_c;
  logic            w_accept;
  logic            w_capture;
  logic            w_rsp_done;

  // Split the flat requester buses into per-requester operand lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_din_a[gi] = req_din[DW*gi +: DW];
    assign w_n_a[gi]   = req_n[NW*gi +: NW];
  end

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    v_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      v_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
  end

  // One-hot grant, only offered in IDLE and suppressed while reset is applied.
  always_comb begin
    w_req_ready_c = '0;
    if ((r_state == S_IDLE) && w_found && !rst) begin
      w_req_ready_c[w_gnt_idx] = 1'b1;
    end
  end

  // Next-state and control strobes for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer, latency counter and shifter operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_sh_din <= '0;
      r_sh_dir <= 1'b0;
      r_sh_n   <= '0;
      r_rsp_id <= '0;
    end else if (w_accept) begin
      r_sh_din <= w_din_a[w_gnt_idx];
      r_sh_dir <= req_dir[w_gnt_idx];
      r_sh_n   <= w_n_a[w_gnt_idx];
      r_rsp_id <= w_gnt_idx;
      r_ptr    <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
      r_cnt    <= CW'(SH_LAT);
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Response capture and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_rsp_data <= sh_dout;
      end
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ready = w_req_ready_c;
  assign sh_din    = r_sh_din;
  assign sh_dir    = r_sh_dir;
  assign sh_n      = r_sh_n;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;

  // Handshake strobe kept for readability of the RESP exit condition.
  logic w_unused;
  assign w_unused = w_rsp_done;

endmodule
